// File: rtl/cpu_pkg.sv
// Types and constants shared along the saturating-exception path of the 8-bit CPU
// (the EX-stage detector and exception_handler both import this package).
package cpu_pkg;

    typedef enum logic [1:0] {
        EXC_NONE = 2'b00,
        EXC_POS  = 2'b01,
        EXC_NEG  = 2'b10,
        EXC_RSVD = 2'b11
    } exc_code_t;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_HI,
        S_WR_LO,
        S_DONE
    } handler_state_t;

endpackage

// File: rtl/exception_handler.sv
// Saturating-exception responder: freezes and flushes the pipeline front, then writes the
// 16-bit saturation value into a register pair one byte per granted write-port cycle.
import cpu_pkg::*;

module exception_handler #(
    parameter logic [2:0] HI_REG = 3'd1,
    parameter logic [2:0] LO_REG = 3'd2,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       exception_code,
    input  logic             wb_ready,
    output logic             stall,
    output logic             flush,
    output logic             rf_we,
    output logic [2:0]       rf_waddr,
    output logic [7:0]       rf_wdata,
    output logic             done,
    output logic [CNT_W-1:0] exc_count,
    output logic             spurious
);

    handler_state_t state, next_state;
    exc_code_t      code;
    logic [15:0]    result_q;
    logic           take_exc;

    assign code     = exc_code_t'(exception_code);
    assign take_exc = (code == EXC_POS) || (code == EXC_NEG);

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        flush      = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = 3'd0;
        rf_wdata   = 8'd0;
        done       = 1'b0;
        case (state)
            // rst_n gating keeps every output low while reset is held, whatever the code input.
            S_IDLE: begin
                if (rst_n && take_exc) begin
                    stall      = 1'b1;
                    flush      = 1'b1;
                    next_state = S_WR_HI;
                end
            end
            S_WR_HI: begin
                stall    = 1'b1;
                rf_we    = wb_ready;
                rf_waddr = HI_REG;
                rf_wdata = result_q[15:8];
                if (wb_ready) next_state = S_WR_LO;
            end
            S_WR_LO: begin
                stall    = 1'b1;
                rf_we    = wb_ready;
                rf_waddr = LO_REG;
                rf_wdata = result_q[7:0];
                if (wb_ready) next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            result_q  <= 16'd0;
            exc_count <= '0;
            spurious  <= 1'b0;
        end else begin
            state <= next_state;
            // The code is only meaningful in IDLE; busy states ignore it entirely.
            if (state == S_IDLE) begin
                if (take_exc) begin
                    result_q <= (code == EXC_POS) ? SAT_POS : SAT_NEG;
                    if (exc_count != '1) exc_count <= exc_count + CNT_W'(1);
                end
                if (code == EXC_RSVD) spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exception_handler.sv
// Bench for exception_handler: a queue-of-pending-writes model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_exception_handler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] exception_code;
    logic       wb_ready;
    logic       stall, flush, rf_we, done, spurious;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] exc_count;

    int n_vec = 0;
    int n_err = 0;

    exception_handler #(.HI_REG(3'd1), .LO_REG(3'd2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .exception_code(exception_code), .wb_ready(wb_ready),
        .stall(stall), .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .done(done), .exc_count(exc_count), .spurious(spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: an exception turns into two pending byte writes followed by a done cycle.
    logic [10:0] wq[$];
    bit          done_pend;
    int          m_cnt;
    bit          m_spur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq.delete();
            done_pend = 0;
            m_cnt     = 0;
            m_spur    = 0;
        end else if (wq.size() > 0) begin
            if (wb_ready) void'(wq.pop_front());
        end else if (done_pend) begin
            done_pend = 0;
        end else if (exception_code == 2'b01 || exception_code == 2'b10) begin
            wq.push_back({3'd1, (exception_code == 2'b01) ? 8'h7F : 8'h80});
            wq.push_back({3'd2, (exception_code == 2'b01) ? 8'hFF : 8'h00});
            done_pend = 1;
            if (m_cnt < 255) m_cnt++;
        end else if (exception_code == 2'b11) begin
            m_spur = 1;
        end
    end

    always @(negedge clk) begin
        logic       e_stall, e_flush, e_we, e_done;
        logic [2:0] e_addr;
        logic [7:0] e_data;
        e_stall = 0; e_flush = 0; e_we = 0; e_done = 0; e_addr = 0; e_data = 0;
        if (rst_n) begin
            if (wq.size() > 0) begin
                e_stall = 1;
                e_we    = wb_ready;
                e_addr  = wq[0][10:8];
                e_data  = wq[0][7:0];
            end else if (done_pend) begin
                e_done = 1;
            end else if (exception_code == 2'b01 || exception_code == 2'b10) begin
                e_stall = 1;
                e_flush = 1;
            end
        end
        chk("stall", stall, e_stall);
        chk("flush", flush, e_flush);
        chk("rf_we", rf_we, e_we);
        if (e_we || e_stall && !e_flush) begin
            chk("rf_waddr", rf_waddr, e_addr);
            chk("rf_wdata", rf_wdata, e_data);
        end
        chk("done", done, e_done);
        chk("exc_count", exc_count, rst_n ? m_cnt : 0);
        chk("spurious", spurious, rst_n ? m_spur : 0);
    end

    task automatic next_cycle(input logic [1:0] code, input logic wr);
        @(posedge clk);
        #1;
        exception_code = code;
        wb_ready       = wr;
    endtask

    initial begin
        int n_done, n_wr;
        rst_n = 1'b0; exception_code = 2'b00; wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lit_reset_count", exc_count, 8'd0);
        chk("lit_reset_stall", stall, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Positive saturate, write port always granted
        next_cycle(2'b01, 1'b1);
        @(negedge clk); chk("lit_pos_detect", {stall, flush}, 2'b11);
        next_cycle(2'b00, 1'b1);
        @(negedge clk); chk("lit_pos_hi", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd1, 8'h7F});
        next_cycle(2'b00, 1'b1);
        @(negedge clk); chk("lit_pos_lo", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd2, 8'hFF});
        next_cycle(2'b00, 1'b1);
        @(negedge clk); chk("lit_pos_done", {done, stall, exc_count}, {1'b1, 1'b0, 8'd1});

        // Negative saturate with the write port withheld for two cycles
        next_cycle(2'b10, 1'b1);
        next_cycle(2'b00, 1'b0);
        @(negedge clk); chk("lit_neg_wait1", {stall, rf_we, rf_waddr, rf_wdata}, {1'b1, 1'b0, 3'd1, 8'h80});
        next_cycle(2'b00, 1'b0);
        @(negedge clk); chk("lit_neg_wait2", {stall, rf_we, rf_waddr, rf_wdata}, {1'b1, 1'b0, 3'd1, 8'h80});
        next_cycle(2'b00, 1'b1);
        @(negedge clk); chk("lit_neg_hi", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd1, 8'h80});
        next_cycle(2'b00, 1'b1);
        @(negedge clk); chk("lit_neg_lo", {rf_we, rf_waddr, rf_wdata}, {1'b1, 3'd2, 8'h00});
        next_cycle(2'b00, 1'b1);
        @(negedge clk); chk("lit_neg_done", {done, exc_count}, {1'b1, 8'd2});

        // Reserved code in IDLE
        next_cycle(2'b11, 1'b1);
        @(negedge clk); chk("lit_rsvd_quiet", {stall, flush, rf_we}, 3'b000);
        next_cycle(2'b00, 1'b1);
        repeat (3) next_cycle(2'b00, 1'b1);
        @(negedge clk); chk("lit_spurious_sticky", spurious, 1'b1);

        // Code held at 01 through the whole sequence counts once
        repeat (4) next_cycle(2'b01, 1'b1);
        next_cycle(2'b00, 1'b1);
        @(negedge clk); chk("lit_hold_count", exc_count, 8'd3);

        // Reset in the middle of WR_HI
        next_cycle(2'b01, 1'b1);
        next_cycle(2'b00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_midreset_outs", {stall, flush, rf_we, done, spurious}, 5'b0);
        chk("lit_midreset_count", exc_count, 8'd0);
        @(posedge clk); #1 rst_n = 1'b1; wb_ready = 1'b1;

        // 256 back-to-back events saturate the counter
        n_done = 0; n_wr = 0;
        for (int i = 0; i < 256; i++) begin
            next_cycle(2'b01, 1'b1);
            for (int k = 0; k < 3; k++) begin
                next_cycle(2'b00, 1'b1);
                @(negedge clk);
                n_done += int'(done);
                n_wr   += int'(rf_we);
            end
        end
        chk("lit_sat_count", exc_count, 8'd255);
        chk("lit_sat_dones", n_done, 256);
        chk("lit_sat_writes", n_wr, 512);
        next_cycle(2'b00, 1'b1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exception_handler.md
Name: exception_handler

Overview:
- Responder side of the saturating-exception path in the 8-bit pipelined CPU.
- Consumes the 2-bit exception code raised on the EX stage. Freezes the front of the pipeline and squashes the faulting instruction.
- Writes the 16-bit saturation result (0x7FFF or 0x8000) into a fixed register pair through the shared register-file write port, one byte per granted cycle.
- Then releases the pipeline and keeps a small amount of sticky status.

Parameters:
- HI_REG, 3'd1, register-file address that receives result[15:8]
- LO_REG, 3'd2, register-file address that receives result[7:0]
- CNT_W, 8, width of the saturating exception counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- exception_code  input  2  from EX-stage detector: 00 none, 01 positive saturate (0x7FFF), 10 negative saturate (0x8000), 11 reserved
- wb_ready  input  1  register-file write port granted to this block this cycle
- stall  output  1  hold PC and IF/ID
- flush  output  1  clear ID/EX on next edge; overrides stall for ID/EX
- rf_we  output  1  register-file write enable
- rf_waddr  output  3  register-file write address
- rf_wdata  output  8  register-file write data
- done  output  1  single-cycle pulse when handling completes
- exc_count  output  CNT_W  number of handled exceptions, saturating
- spurious  output  1  sticky; set when code 11 is seen in IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, result reg=0, exc_count=0, spurious=0. All outputs 0 immediately.
- stall, flush, rf_* and done are decoded combinationally from state (and from exception_code in IDLE only). All internal state is registered.
- States: IDLE, WR_HI, WR_LO, DONE.
- IDLE, code 01 or 10 (detect cycle):
  - stall=1, flush=1.
  - Latch result = 0x7FFF for 01, 0x8000 for 10.
  - exc_count += 1, holding at 2^CNT_W-1.
  - Next state WR_HI.
  - The faulting instruction becomes a bubble, so the detector sees 00 from the next cycle on.
- IDLE, code 11: no stall or flush, spurious<=1, stay in IDLE.
- IDLE, code 00: all outputs 0.
- WR_HI:
  - stall=1, rf_we=wb_ready, rf_waddr=HI_REG, rf_wdata=result[15:8].
  - Go to WR_LO on wb_ready=1, else hold.
  - rf_waddr/rf_wdata stay stable while waiting.
- WR_LO: same as WR_HI with LO_REG and result[7:0]; go to DONE on wb_ready=1.
- DONE: stall=0, done=1, next IDLE. The pipeline resumes on this cycle's edge.
- Latency with wb_ready held at 1: detect cycle N; HI write N+1; LO write N+2; done N+3; stall high for cycles N..N+2 (3 cycles).
- exception_code is ignored in WR_HI, WR_LO and DONE: no retrigger and no count change.
- Back-to-back exceptions: a new nonzero code can be accepted in the IDLE cycle immediately after DONE.
- Reset mid-operation: returns to IDLE at once. Any byte already written stays written; there is no completion or rollback.
- The block never asserts rf_we when wb_ready=0.

Decomposition:
- Shared package cpu_pkg holds:
  - exc_code_t enum: EXC_NONE, EXC_POS, EXC_NEG, EXC_RSVD.
  - Constants SAT_POS=16'h7FFF and SAT_NEG=16'h8000.
  - handler state enum.
- The detector and this block both import exc_code_t.
- No sub-module. The saturating counter is inline (small enough).

Test Plan:
- Reset: assert rst_n=0 mid-WR_HI -> state IDLE, all outputs 0 in the same cycle; exc_count=0.
- code=01 for 1 cycle, wb_ready=1 -> cycle N stall=1 flush=1; N+1 write addr1 data 0x7F; N+2 addr2 data 0xFF; N+3 done=1 stall=0; exc_count=1.
- code=10, wb_ready low 2 cycles in WR_HI then high -> addr1/0x80 held stable with rf_we=0; write occurs on the grant; LO write addr2/0x00 follows; stall held throughout.
- code=11 in IDLE -> no stall, flush or write; spurious=1 and stays 1 afterwards.
- code held at 01 through WR_HI/WR_LO/DONE -> exactly one handling sequence; exc_count increments by 1 only.
- 256 back-to-back code=01 events with CNT_W=8 -> exc_count saturates at 255; each event still produces both writes and a done pulse.
